// File: rtl/word_serializer.sv
// Word-to-symbol serializer: accepts DATA_W-bit words and emits them as N = DATA_W/OUT_W
// symbols of OUT_W bits, LSB- or MSB-symbol first, with abort and back-to-back reload.
module word_serializer #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned OUT_W     = 8,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   input  logic              abort_i,
   output logic              out_valid_o,
   output logic [OUT_W-1:0]  out_data_o,
   output logic              out_last_o,
   input  logic              out_ready_i,
   output logic              busy_o
);

   localparam int unsigned N       = DATA_W / OUT_W;
   localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e            state_q;
   logic [DATA_W-1:0] word_q;
   logic [IdxW-1:0]   idx_q;
   logic [OUT_W-1:0]  out_data_q;
   logic              out_last_q;

   logic              in_hs;
   logic              out_hs;
   logic              at_last;
   logic [IdxW-1:0]   idx_inc;

   // Symbol k of a word in transmit order.
   function automatic logic [OUT_W-1:0] sym_of(input logic [DATA_W-1:0] w,
                                                input logic [IdxW-1:0]   k);
      logic [OUT_W-1:0] s;
      s = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (k == IdxW'(i)) begin
            if (MSB_FIRST != 0) s = w[(N-1-i)*OUT_W +: OUT_W];
            else                s = w[i*OUT_W +: OUT_W];
         end
      end
      return s;
   endfunction

   assign at_last = (idx_q == LastIdx);
   assign idx_inc = idx_q + 1'b1;

   // A new word may enter while the final symbol of the current one leaves.
   always_comb begin
      in_ready_o = 1'b0;
      if (!rst_i && !abort_i) begin
         in_ready_o = (state_q == StIdle) || (at_last && out_ready_i);
      end
   end

   assign in_hs       = in_valid_i && in_ready_o;
   assign out_hs      = (state_q == StShift) && out_ready_i;
   assign out_valid_o = (state_q == StShift);
   assign busy_o      = (state_q == StShift);
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         word_q     <= '0;
         idx_q      <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else if (abort_i) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         out_last_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_hs) begin
                  word_q     <= in_data_i;
                  idx_q      <= '0;
                  out_data_q <= sym_of(in_data_i, {IdxW{1'b0}});
                  out_last_q <= (LastIdx == {IdxW{1'b0}});
                  state_q    <= StShift;
               end
            end
            StShift: begin
               if (out_hs) begin
                  if (at_last) begin
                     if (in_hs) begin
                        word_q     <= in_data_i;
                        idx_q      <= '0;
                        out_data_q <= sym_of(in_data_i, {IdxW{1'b0}});
                        out_last_q <= (LastIdx == {IdxW{1'b0}});
                     end else begin
                        state_q    <= StIdle;
                        idx_q      <= '0;
                        out_last_q <= 1'b0;
                     end
                  end else begin
                     idx_q      <= idx_inc;
                     out_data_q <= sym_of(word_q, idx_inc);
                     out_last_q <= (idx_inc == LastIdx);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: LSB-first and MSB-first instances share stimulus; directed
// table and corner sequences, then random traffic against a symbol-queue model.
module tb_word_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_data;
   logic        abort;
   logic        out_ready;

   logic        l_in_ready, l_out_valid, l_out_last, l_busy;
   logic [7:0]  l_out_data;
   logic        m_in_ready, m_out_valid, m_out_last, m_busy;
   logic [7:0]  m_out_data;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] ql[$];
   logic [7:0] qm[$];
   logic       exp_ready;

   typedef struct {
      logic [63:0] word;
      logic [63:0] lsb_stream;  // observed symbols, first one in bits [7:0]
      logic [63:0] msb_stream;
   } vec_t;
   vec_t tbl[4];

   always #5 clk = ~clk;

   word_serializer #(.DATA_W(64), .OUT_W(8), .MSB_FIRST(0)) u_lsb (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(l_in_ready), .abort_i(abort), .out_valid_o(l_out_valid),
      .out_data_o(l_out_data), .out_last_o(l_out_last), .out_ready_i(out_ready),
      .busy_o(l_busy)
   );

   word_serializer #(.DATA_W(64), .OUT_W(8), .MSB_FIRST(1)) u_msb (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(m_in_ready), .abort_i(abort), .out_valid_o(m_out_valid),
      .out_data_o(m_out_data), .out_last_o(m_out_last), .out_ready_i(out_ready),
      .busy_o(m_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic accept(input logic [63:0] w);
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      settle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{64'h0807060504030201, 64'h0807060504030201, 64'h0102030405060708};
      tbl[1] = '{64'hDEADBEEF01234567, 64'hDEADBEEF01234567, 64'h67452301EFBEADDE};
      tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
      tbl[3] = '{64'h00000000000000A5, 64'h00000000000000A5, 64'hA500000000000000};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b1;
      step();
      step();
      settle();
      check("rst_valid", l_out_valid, 0);
      check("rst_data", l_out_data, 0);
      check("rst_last", l_out_last, 0);
      check("rst_busy", l_busy, 0);
      check("rst_in_ready", l_in_ready, 0);
      rst = 1'b0;
      settle();
      check("rel_in_ready", l_in_ready, 1);

      // Table: one word each, out_ready held high, both symbol orders.
      for (int t = 0; t < 4; t++) begin
         in_valid = 1'b1; in_data = tbl[t].word; out_ready = 1'b1;
         settle();
         check("tbl_in_ready", l_in_ready, 1);
         step();
         in_valid = 1'b0; in_data = {$urandom, $urandom};
         settle();
         for (int i = 0; i < 8; i++) begin
            check("tbl_valid", l_out_valid, 1);
            check("tbl_lsb_data", l_out_data, tbl[t].lsb_stream[i*8 +: 8]);
            check("tbl_msb_data", m_out_data, tbl[t].msb_stream[i*8 +: 8]);
            check("tbl_lsb_last", l_out_last, (i == 7));
            check("tbl_msb_last", m_out_last, (i == 7));
            step();
         end
         check("tbl_idle", l_out_valid, 0);
         check("tbl_idle_msb", m_out_valid, 0);
      end

      // Stall three cycles on symbol 03.
      accept(64'h0807060504030201);
      step();
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("stall_data", l_out_data, 8'h03);
         check("stall_valid", l_out_valid, 1);
         check("stall_last", l_out_last, 0);
         step();
      end
      out_ready = 1'b1;
      settle();
      for (int k = 3; k <= 8; k++) begin
         check("resume_data", l_out_data, k);
         check("resume_last", l_out_last, (k == 8));
         step();
      end
      check("resume_idle", l_out_valid, 0);

      // Back-to-back words, no bubble.
      in_valid = 1'b1; in_data = 64'h0807060504030201; out_ready = 1'b1;
      step();
      in_data = 64'h1817161514131211;
      for (int i = 0; i < 16; i++) begin
         in_valid = (i < 8);
         settle();
         check("b2b_valid", l_out_valid, 1);
         check("b2b_lsb", l_out_data, (i < 8) ? (i + 1) : (8'h11 + i - 8));
         check("b2b_msb", m_out_data, (i < 8) ? (8 - i) : (8'h18 - (i - 8)));
         check("b2b_in_ready", l_in_ready, (i == 7 || i == 15));
         step();
      end
      in_valid = 1'b0;
      settle();
      check("b2b_idle", l_out_valid, 0);

      // Abort after three symbols, then restart.
      accept(64'h0807060504030201);
      step();
      step();
      step();
      check("abort_pre_data", l_out_data, 8'h04);
      abort = 1'b1;
      settle();
      check("abort_in_ready", l_in_ready, 0);
      step();
      abort = 1'b0;
      settle();
      check("abort_valid", l_out_valid, 0);
      check("abort_last", l_out_last, 0);
      check("abort_busy", l_busy, 0);
      check("abort_rel_ready", l_in_ready, 1);
      accept(64'h1111111111111111);
      for (int i = 0; i < 8; i++) begin
         check("restart_valid", l_out_valid, 1);
         check("restart_data", l_out_data, 8'h11);
         check("restart_last", l_out_last, (i == 7));
         step();
      end
      check("restart_idle", l_out_valid, 0);

      // Abort while idle blocks a load.
      abort = 1'b1; in_valid = 1'b1; in_data = 64'h0807060504030201;
      settle();
      check("idle_abort_ready", l_in_ready, 0);
      step();
      abort = 1'b0; in_valid = 1'b0;
      settle();
      check("idle_abort_valid", l_out_valid, 0);

      // Reset during symbol 5.
      accept(64'h0807060504030201);
      for (int i = 0; i < 4; i++) step();
      check("rst_mid_pre", l_out_data, 8'h05);
      rst = 1'b1;
      settle();
      check("rst_mid_ready_now", l_in_ready, 0);
      step();
      check("rst_mid_valid", l_out_valid, 0);
      check("rst_mid_data", l_out_data, 0);
      check("rst_mid_msb_data", m_out_data, 0);
      check("rst_mid_busy", l_busy, 0);
      check("rst_mid_last", l_out_last, 0);
      check("rst_mid_ready", l_in_ready, 0);
      rst = 1'b0;
      settle();
      check("rst_mid_rel", l_in_ready, 1);

      // Random traffic against a queue of expected symbols per order.
      ql.delete();
      qm.delete();
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(63) == 0);
         abort     = ($urandom_range(31) == 0);
         in_valid  = ($urandom_range(2) != 0);
         in_data   = {$urandom, $urandom};
         out_ready = ($urandom_range(3) != 0);
         settle();
         exp_ready = !rst && !abort && (ql.size() == 0 || (ql.size() == 1 && out_ready));
         check("rnd_in_ready", l_in_ready, exp_ready);
         check("rnd_msb_in_ready", m_in_ready, exp_ready);
         check("rnd_valid", l_out_valid, (ql.size() != 0));
         check("rnd_busy", m_busy, (qm.size() != 0));
         if (ql.size() != 0) begin
            check("rnd_lsb_data", l_out_data, ql[0]);
            check("rnd_msb_data", m_out_data, qm[0]);
            check("rnd_last", l_out_last, (ql.size() == 1));
         end else begin
            check("rnd_idle_last", l_out_last, 0);
         end
         if (rst) begin
            ql.delete();
            qm.delete();
         end else begin
            if (ql.size() != 0 && out_ready) begin
               void'(ql.pop_front());
               void'(qm.pop_front());
            end
            if (abort) begin
               ql.delete();
               qm.delete();
            end else if (in_valid && exp_ready) begin
               for (int k = 0; k < 8; k++) begin
                  ql.push_back(in_data[k*8 +: 8]);
                  qm.push_back(in_data[(7-k)*8 +: 8]);
               end
            end
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
